oa21_stim_chk: RTL and testbench
================================

OA21_STIM_CHK -- requirements
Module: oa21_stim_chk

Interface
REQ-001 Parameter LOOPS, default 1, number of full 8-pattern passes per run; legal range 1..1024.
REQ-002 Parameter LAT, default 1, cycles from a pattern being driven to its Q sample; legal range 1..4.
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  run request, sampled on CLK edges.
REQ-006 Q  input  1  response from the OA21-function cell under test.
REQ-007 IN1, IN2, IN3  output  1 each  registered stimulus to the cell under test.
REQ-008 BUSY  output  1  run in progress.
REQ-009 DONE  output  1  run complete; results valid.
REQ-010 PASS  output  1  high when DONE is high and ERRCNT is 0.
REQ-011 ERRCNT  output  8  count of mismatching samples; saturates at 255.
REQ-012 TOGCNT  output  16  count of Q transitions between consecutive valid samples; saturates at 65535.

Function
REQ-013 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE->RUN on START=1; DONE->RUN on START=1; RUN->DRAIN after the last pattern; DRAIN->DONE at the final sample edge.
REQ-015 START is ignored in RUN and DRAIN.
REQ-016 Entering RUN clears ERRCNT, TOGCNT and the previous-sample register, and deasserts DONE and PASS.
REQ-017 Pattern order {IN3,IN2,IN1} is Gray: 000,001,011,010,110,111,101,100, repeated LOOPS times, for N = 8*LOOPS patterns.
REQ-018 Exactly one pattern is applied per cycle.
REQ-019 If START is sampled at edge 0, pattern k (k = 1..N) is driven during the cycle after edge k.
REQ-020 Expected value = (IN1|IN2)&IN3, carried with a valid bit through an LAT-deep shift register.
REQ-021 Q for pattern k is sampled at edge k+LAT and compared with its expected value.
REQ-022 On a mismatch, ERRCNT increments by 1 and holds at 255 (no wrap).
REQ-023 On each valid sample after the first, TOGCNT increments if Q differs from the previous valid sample, and holds at 65535.
REQ-024 In DRAIN, IN1..IN3 are driven to 000 and comparisons continue until the valid pipeline is empty.
REQ-025 DONE=1, BUSY=0 and PASS=(ERRCNT==0) are registered at edge N+LAT and held until the next START or reset.
REQ-026 BUSY=1 exactly in RUN and DRAIN.
REQ-027 IN1..IN3 = 000 in IDLE and DONE.
REQ-028 A sample edge that coincides with the RUN->DRAIN transition is still compared.
REQ-029 The pattern counter wraps from the last Gray code back to 000 only between loops, never beyond N.

Reset
REQ-030 While RST=1, outputs are forced immediately, independent of CLK: IN1..IN3=0, BUSY=0, DONE=0, PASS=0, ERRCNT=0, TOGCNT=0; FSM=IDLE; pipeline valid bits=0.
REQ-031 Reset asserted mid-run aborts the run with no residual state; after release, a new START is required to begin a run.

Verification
REQ-032 Reset: assert RST with CLK stopped -> all outputs 0 immediately; release, no START -> outputs stay 0.
REQ-033 Ideal zero-delay DUT, LOOPS=1, LAT=1, START at edge 0 -> DONE=1 from edge 9, ERRCNT=0, PASS=1, TOGCNT=2 (Q sequence 0,0,0,0,1,1,1,0).
REQ-034 Q stuck at 0, LOOPS=100 -> 300 mismatches expected; ERRCNT=255 (saturated), TOGCNT=0, PASS=0, DONE at edge 801.
REQ-035 Reset pulse at edge 4 of a run -> IN=000, BUSY=0, counters=0; a following START gives a full clean run matching REQ-033.
REQ-036 START pulsed during RUN -> no effect, DONE timing unchanged; START while in DONE -> counters cleared and a new run starts at the next edge.
REQ-037 LAT=3 with a DUT modelled with 2 registers of delay (Q valid 3 cycles late) -> PASS=1; same DUT with LAT=2 -> ERRCNT>0, PASS=0.

Source files
------------

// File: rtl/oa21_stim_chk.sv
// oa21_stim_chk -- built-in stimulus generator and response checker for an
// OA21 cell (Q = (IN1 | IN2) & IN3).
//
// A run drives the eight input codes in Gray order, LOOPS times over, one code
// per cycle. Each code's expected response travels with a valid bit through an
// LAT-deep pipeline and is compared against Q when it reaches the end. Mismatches
// and Q transitions between consecutive samples are counted with saturation.
//
// Ports
//   CLK     in   sole clock, rising edge
//   RST     in   asynchronous active-high reset
//   START   in   run request (honoured in IDLE and DONE only)
//   Q       in   response of the cell under test
//   IN1..3  out  registered stimulus to the cell
//   BUSY    out  run in progress (RUN or DRAIN)
//   DONE    out  run complete, results valid
//   PASS    out  DONE and no mismatches
//   ERRCNT  out  mismatch count, saturates at 255
//   TOGCNT  out  Q transitions between consecutive samples, saturates at 65535
module oa21_stim_chk #(
    parameter int LOOPS = 1,
    parameter int LAT   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        Q,
    output logic        IN1,
    output logic        IN2,
    output logic        IN3,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [7:0]  ERRCNT,
    output logic [15:0] TOGCNT
);

    localparam int N     = 8 * LOOPS;
    localparam int CNT_W = $clog2(N) + 1;
    // Pipeline holds only its oldest entry: the final sample is at this edge.
    localparam logic [LAT-1:0] VLD_TOP = LAT'(1) << (LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pat_q, pat_d;      // {IN3, IN2, IN1}
    logic [LAT-1:0]   vld_q, vld_d;
    logic [LAT-1:0]   exp_q, exp_d;
    logic [7:0]       err_q, err_d;
    logic [15:0]      tog_q, tog_d;
    logic             prev_q, prev_d;
    logic             have_q, have_d;    // a previous sample exists this run

    logic start_run;
    logic last_pat;
    logic drain_end;
    logic push;
    logic exp_new;

    function automatic logic [2:0] gray3(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign start_run = START && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_pat  = (state_q == S_RUN) && (cnt_q == CNT_W'(N - 1));
    assign drain_end = (state_q == S_DRAIN) && (vld_q == VLD_TOP);

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_run) state_d = S_RUN;
            S_RUN:   if (last_pat)  state_d = S_DRAIN;
            S_DRAIN: if (drain_end) state_d = S_DONE;
            S_DONE:  if (start_run) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        BUSY   = (state_q == S_RUN) || (state_q == S_DRAIN);
        DONE   = (state_q == S_DONE);
        PASS   = (state_q == S_DONE) && (err_q == 8'd0);
        IN1    = pat_q[0];
        IN2    = pat_q[1];
        IN3    = pat_q[2];
        ERRCNT = err_q;
        TOGCNT = tog_q;
    end

    // Stimulus, expected-value pipeline and result counters
    always_comb begin
        cnt_d   = cnt_q;
        pat_d   = 3'b000;
        err_d   = err_q;
        tog_d   = tog_q;
        prev_d  = prev_q;
        have_d  = have_q;
        push    = 1'b0;
        exp_new = 1'b0;
        vld_d   = '0;
        exp_d   = '0;

        if (state_q == S_RUN) begin
            pat_d   = gray3(cnt_q[2:0]);
            cnt_d   = cnt_q + CNT_W'(1);
            push    = 1'b1;
            exp_new = (pat_d[0] | pat_d[1]) & pat_d[2];
        end

        vld_d[0] = push;
        exp_d[0] = exp_new;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            exp_d[i] = exp_q[i-1];
        end

        // Oldest pipeline entry lines up with the Q of its pattern.
        if (vld_q[LAT-1]) begin
            if (Q != exp_q[LAT-1]) begin
                err_d = sat_inc8(err_q);
            end
            if (have_q && (Q != prev_q)) begin
                tog_d = sat_inc16(tog_q);
            end
            prev_d = Q;
            have_d = 1'b1;
        end

        if (start_run) begin
            cnt_d  = '0;
            err_d  = '0;
            tog_d  = '0;
            prev_d = 1'b0;
            have_d = 1'b0;
            vld_d  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= '0;
            pat_q  <= 3'b000;
            vld_q  <= '0;
            err_q  <= 8'd0;
            tog_q  <= 16'd0;
            prev_q <= 1'b0;
            have_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pat_q  <= pat_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            tog_q  <= tog_d;
            prev_q <= prev_d;
            have_q <= have_d;
        end
    end

    // Expected values are qualified by vld_q, so they need no reset.
    always_ff @(posedge CLK) begin
        exp_q <= exp_d;
    end

endmodule

// File: tb/tb_oa21_stim_chk.sv
// Bench for oa21_stim_chk: five instances sharing clock and reset.
//   u0  LOOPS=1   LAT=1  ideal zero-delay OA21 cell
//   u1  LOOPS=100 LAT=1  Q stuck at 0
//   u2  LOOPS=1   LAT=3  cell with two registers of delay
//   u3  LOOPS=1   LAT=2  same delayed cell, latency set too short
//   u4  LOOPS=2   LAT=2  random Q, checked against a reference model
module tb_oa21_stim_chk;

    localparam logic [2:0] GRAY [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                        3'b110, 3'b111, 3'b101, 3'b100};

    logic CLK = 1'b0;
    logic clk_en = 1'b0;
    logic RST = 1'b0;

    logic st_0, st_1, st_2, st_3, st_4;
    logic q_0, q_1, q_2, q_3, q_4;
    logic in1_0, in2_0, in3_0, busy_0, done_0, pass_0;
    logic in1_1, in2_1, in3_1, busy_1, done_1, pass_1;
    logic in1_2, in2_2, in3_2, busy_2, done_2, pass_2;
    logic in1_3, in2_3, in3_3, busy_3, done_3, pass_3;
    logic in1_4, in2_4, in3_4, busy_4, done_4, pass_4;
    logic [7:0]  err_0, err_1, err_2, err_3, err_4;
    logic [15:0] tog_0, tog_1, tog_2, tog_3, tog_4;

    logic d2a = 1'b0, d2b = 1'b0, d3a = 1'b0, d3b = 1'b0;

    // Q value presented to each instance just before edge number idx.
    logic qrec [5][0:1023];

    int n_cmp = 0;
    int n_mis = 0;
    int m_err, m_tog;

    always #5 CLK = clk_en ? ~CLK : CLK;

    assign q_0 = (in1_0 | in2_0) & in3_0;
    assign q_1 = 1'b0;
    assign q_2 = d2b;
    assign q_3 = d3b;

    always @(posedge CLK) begin
        d2a <= (in1_2 | in2_2) & in3_2;
        d2b <= d2a;
        d3a <= (in1_3 | in2_3) & in3_3;
        d3b <= d3a;
    end

    oa21_stim_chk #(.LOOPS(1), .LAT(1)) u0 (
        .CLK(CLK), .RST(RST), .START(st_0), .Q(q_0),
        .IN1(in1_0), .IN2(in2_0), .IN3(in3_0), .BUSY(busy_0), .DONE(done_0),
        .PASS(pass_0), .ERRCNT(err_0), .TOGCNT(tog_0));

    oa21_stim_chk #(.LOOPS(100), .LAT(1)) u1 (
        .CLK(CLK), .RST(RST), .START(st_1), .Q(q_1),
        .IN1(in1_1), .IN2(in2_1), .IN3(in3_1), .BUSY(busy_1), .DONE(done_1),
        .PASS(pass_1), .ERRCNT(err_1), .TOGCNT(tog_1));

    oa21_stim_chk #(.LOOPS(1), .LAT(3)) u2 (
        .CLK(CLK), .RST(RST), .START(st_2), .Q(q_2),
        .IN1(in1_2), .IN2(in2_2), .IN3(in3_2), .BUSY(busy_2), .DONE(done_2),
        .PASS(pass_2), .ERRCNT(err_2), .TOGCNT(tog_2));

    oa21_stim_chk #(.LOOPS(1), .LAT(2)) u3 (
        .CLK(CLK), .RST(RST), .START(st_3), .Q(q_3),
        .IN1(in1_3), .IN2(in2_3), .IN3(in3_3), .BUSY(busy_3), .DONE(done_3),
        .PASS(pass_3), .ERRCNT(err_3), .TOGCNT(tog_3));

    oa21_stim_chk #(.LOOPS(2), .LAT(2)) u4 (
        .CLK(CLK), .RST(RST), .START(st_4), .Q(q_4),
        .IN1(in1_4), .IN2(in2_4), .IN3(in3_4), .BUSY(busy_4), .DONE(done_4),
        .PASS(pass_4), .ERRCNT(err_4), .TOGCNT(tog_4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Record the Q each instance will sample, take the edge, then move
    // 1 time unit past it to drive and observe.
    task automatic tick(input int idx);
        qrec[0][idx] = q_0;
        qrec[1][idx] = q_1;
        qrec[2][idx] = q_2;
        qrec[3][idx] = q_3;
        qrec[4][idx] = q_4;
        @(posedge CLK);
        #1;
        q_4 = 1'($urandom_range(0, 1));
    endtask

    // Reference: pattern k is the Gray table entry, its expected response is
    // the OA21 function, and its Q is the one present at edge k+lat.
    function automatic void ref_run(input int id, input int loops, input int lat,
                                    output int err, output int tog);
        logic [2:0] g;
        logic ev, qv, pv;
        err = 0;
        tog = 0;
        pv  = 1'b0;
        for (int k = 1; k <= 8 * loops; k++) begin
            g  = GRAY[(k - 1) % 8];
            ev = (g[0] | g[1]) & g[2];
            qv = qrec[id][k + lat];
            if ((qv !== ev) && (err < 255)) err++;
            if ((k > 1) && (qv !== pv) && (tog < 65535)) tog++;
            pv = qv;
        end
    endfunction

    task automatic chk_u0_run_step(input int e);
        if (e >= 1 && e <= 8) begin
            chk("u0_pattern", 32'({in3_0, in2_0, in1_0}), 32'(GRAY[e - 1]));
        end
        if (e == 8) begin
            chk("u0_busy_e8", 32'(busy_0), 32'(1));
            chk("u0_done_e8", 32'(done_0), 32'(0));
        end
        if (e == 9) begin
            chk("u0_done_e9", 32'(done_0), 32'(1));
            chk("u0_busy_e9", 32'(busy_0), 32'(0));
            chk("u0_pass_e9", 32'(pass_0), 32'(1));
            chk("u0_err_e9",  32'(err_0),  32'(0));
            chk("u0_tog_e9",  32'(tog_0),  32'(2));
            chk("u0_in_e9",   32'({in3_0, in2_0, in1_0}), 32'(0));
        end
    endtask

    initial begin
        st_0 = 1'b0; st_1 = 1'b0; st_2 = 1'b0; st_3 = 1'b0; st_4 = 1'b0;
        q_4  = 1'b0;

        // Asynchronous reset with the clock stopped
        #2 RST = 1'b1;
        #1;
        chk("rst_in",   32'({in3_0, in2_0, in1_0}), 32'(0));
        chk("rst_busy", 32'(busy_0), 32'(0));
        chk("rst_done", 32'(done_0), 32'(0));
        chk("rst_pass", 32'(pass_0), 32'(0));
        chk("rst_err",  32'(err_0),  32'(0));
        chk("rst_tog",  32'(tog_0),  32'(0));
        chk("rst_busy_u1", 32'(busy_1), 32'(0));

        clk_en = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) tick(1000);
        chk("idle_in",   32'({in3_0, in2_0, in1_0}), 32'(0));
        chk("idle_busy", 32'(busy_0), 32'(0));
        chk("idle_done", 32'(done_0), 32'(0));

        // Run A: every instance starts at the same edge 0
        st_0 = 1'b1; st_1 = 1'b1; st_2 = 1'b1; st_3 = 1'b1; st_4 = 1'b1;
        tick(0);
        st_0 = 1'b0; st_1 = 1'b0; st_2 = 1'b0; st_3 = 1'b0; st_4 = 1'b0;
        for (int e = 1; e <= 801; e++) begin
            if (e == 4) st_0 = 1'b1;   // ignored: u0 is mid-run
            tick(e);
            st_0 = 1'b0;
            chk_u0_run_step(e);
            if (e == 10) begin
                chk("u2_done_e10", 32'(done_2), 32'(0));
                chk("u3_done_e10", 32'(done_3), 32'(1));
                ref_run(3, 1, 2, m_err, m_tog);
                chk("u3_err", 32'(err_3), 32'(m_err));
                chk("u3_pass", 32'(pass_3), 32'(0));
            end
            if (e == 11) begin
                ref_run(2, 1, 3, m_err, m_tog);
                chk("u2_done_e11", 32'(done_2), 32'(1));
                chk("u2_pass", 32'(pass_2), 32'(1));
                chk("u2_err",  32'(err_2),  32'(m_err));
                chk("u2_tog",  32'(tog_2),  32'(m_tog));
            end
            if (e == 17) chk("u4_done_e17", 32'(done_4), 32'(0));
            if (e == 18) begin
                ref_run(4, 2, 2, m_err, m_tog);
                chk("u4_done_e18", 32'(done_4), 32'(1));
                chk("u4_err",  32'(err_4),  32'(m_err));
                chk("u4_tog",  32'(tog_4),  32'(m_tog));
                chk("u4_pass", 32'(pass_4), 32'(m_err == 0));
            end
            if (e == 800) chk("u1_done_e800", 32'(done_1), 32'(0));
            if (e == 801) begin
                chk("u1_done_e801", 32'(done_1), 32'(1));
                chk("u1_err_sat",   32'(err_1),  32'(255));
                chk("u1_tog",       32'(tog_1),  32'(0));
                chk("u1_pass",      32'(pass_1), 32'(0));
            end
        end

        // Restart u0 from DONE
        st_0 = 1'b1;
        tick(0);
        st_0 = 1'b0;
        chk("rerun_busy", 32'(busy_0), 32'(1));
        chk("rerun_done", 32'(done_0), 32'(0));
        chk("rerun_pass", 32'(pass_0), 32'(0));
        chk("rerun_tog",  32'(tog_0),  32'(0));
        for (int e = 1; e <= 9; e++) begin
            tick(e);
            chk_u0_run_step(e);
        end

        // Reset pulse at edge 4 of a run
        st_0 = 1'b1; st_4 = 1'b1;
        tick(0);
        st_0 = 1'b0; st_4 = 1'b0;
        for (int e = 1; e <= 4; e++) tick(e);
        RST = 1'b1;
        #1;
        chk("midrst_in",   32'({in3_0, in2_0, in1_0}), 32'(0));
        chk("midrst_busy", 32'(busy_0), 32'(0));
        chk("midrst_err",  32'(err_0),  32'(0));
        chk("midrst_tog",  32'(tog_0),  32'(0));
        chk("midrst_busy_u4", 32'(busy_4), 32'(0));
        chk("midrst_err_u4",  32'(err_4),  32'(0));
        chk("midrst_tog_u4",  32'(tog_4),  32'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) tick(1000);
        chk("postrst_busy", 32'(busy_0), 32'(0));
        chk("postrst_done", 32'(done_0), 32'(0));
        chk("postrst_busy_u4", 32'(busy_4), 32'(0));

        // Clean run after reset, with a fresh random Q for u4
        st_0 = 1'b1; st_4 = 1'b1;
        tick(0);
        st_0 = 1'b0; st_4 = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            tick(e);
            chk_u0_run_step(e);
            if (e == 18) begin
                ref_run(4, 2, 2, m_err, m_tog);
                chk("u4b_done", 32'(done_4), 32'(1));
                chk("u4b_err",  32'(err_4),  32'(m_err));
                chk("u4b_tog",  32'(tog_4),  32'(m_tog));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
